// File: rtl/traffic_light_pixel_renderer.sv
// Two-stage traffic-light lamp and housing-ring overlay for the pixel-clock domain.
// Optional macro TL_STATE_CHECK_EN: one-hot check of light_state (sticky state_fault, magenta lamps).
module traffic_light_pixel_renderer #(
  parameter int                    NUM_DIR      = 4,
  parameter int                    LAMP_SIZE    = 10,
  parameter int                    RING_W       = 2,
  parameter logic [NUM_DIR*10-1:0] LAMP_X       = {10'd170, 10'd110, 10'd190, 10'd130},
  parameter logic [NUM_DIR*10-1:0] LAMP_Y       = {10'd110, 10'd130, 10'd170, 10'd190},
  parameter int                    BLINK_FRAMES = 30
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   pixel_valid,
  input  logic [9:0]             x,
  input  logic [9:0]             y,
  input  logic                   frame_start,
  input  logic [3*NUM_DIR-1:0]   light_state,
  input  logic                   flash_mode,
  output logic                   out_valid,
  output logic                   shape_active,
  output logic [3:0]             shape_r,
  output logic [3:0]             shape_g,
  output logic [3:0]             shape_b,
  output logic                   state_fault
);

  localparam int                CNT_W   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(BLINK_FRAMES - 1);

  function automatic logic [10:0] sat_lo(input int pos, input int margin);
    int lo;
    lo = pos - margin;
    if (lo < 0) lo = 0;
    return 11'(lo);
  endfunction

`ifdef TL_STATE_CHECK_EN
  function automatic logic one_hot(input logic [2:0] st);
    return (st == 3'b100) || (st == 3'b010) || (st == 3'b001);
  endfunction
`endif

  function automatic logic [11:0] lamp_rgb(input logic [2:0] st, input logic flash,
                                           input logic blink);
    logic [11:0] rgb;
    if (flash)
      rgb = blink ? 12'hFF0 : 12'h000;
`ifdef TL_STATE_CHECK_EN
    else if (!one_hot(st))
      rgb = 12'hF0F;
`endif
    else if (st[2])
      rgb = 12'hF00;
    else if (st[1])
      rgb = 12'hFF0;
    else if (st[0])
      rgb = 12'h0F0;
    else
      rgb = 12'h000;
    return rgb;
  endfunction

  logic [3*NUM_DIR-1:0] state_q;
  logic                 flash_q;
  logic                 blink_on;
  logic [CNT_W-1:0]     frame_cnt;

  // Frame-rate shadow state: only moves on frame_start so colours stay stable within a frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= {NUM_DIR{3'b100}};
      flash_q <= 1'b0;
    end else if (frame_start) begin
      state_q <= light_state;
      flash_q <= flash_mode;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (frame_start) begin
      if (frame_cnt == CNT_MAX) begin
        frame_cnt <= '0;
        blink_on  <= ~blink_on;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  logic [10:0]        x_ext;
  logic [10:0]        y_ext;
  logic [NUM_DIR-1:0] lamp_hit;
  logic [NUM_DIR-1:0] ring_hit;
  logic [11:0]        lamp_rgb_c [NUM_DIR];
`ifdef TL_STATE_CHECK_EN
  logic [NUM_DIR-1:0] bad_state;
`endif

  assign x_ext = {1'b0, x};
  assign y_ext = {1'b0, y};

  for (genvar i = 0; i < NUM_DIR; i++) begin : g_lamp
    localparam int          LX    = int'(LAMP_X[10*i +: 10]);
    localparam int          LY    = int'(LAMP_Y[10*i +: 10]);
    localparam logic [10:0] X_LO  = 11'(LX);
    localparam logic [10:0] X_HI  = 11'(LX + LAMP_SIZE);
    localparam logic [10:0] Y_LO  = 11'(LY);
    localparam logic [10:0] Y_HI  = 11'(LY + LAMP_SIZE);
    localparam logic [10:0] RX_LO = sat_lo(LX, RING_W);
    localparam logic [10:0] RX_HI = 11'(LX + LAMP_SIZE + RING_W);
    localparam logic [10:0] RY_LO = sat_lo(LY, RING_W);
    localparam logic [10:0] RY_HI = 11'(LY + LAMP_SIZE + RING_W);
    logic in_outer;

    assign lamp_hit[i] = (x_ext >= X_LO) && (x_ext < X_HI) && (y_ext >= Y_LO) && (y_ext < Y_HI);
    assign in_outer    = (x_ext >= RX_LO) && (x_ext < RX_HI) && (y_ext >= RY_LO) && (y_ext < RY_HI);
    assign ring_hit[i] = in_outer && !lamp_hit[i];
    // Colour is resolved against pre-update shadow state so a frame_start pixel sees the old frame
    assign lamp_rgb_c[i] = lamp_rgb(state_q[3*i +: 3], flash_q, blink_on);
`ifdef TL_STATE_CHECK_EN
    assign bad_state[i] = !one_hot(light_state[3*i +: 3]);
`endif
  end

  // ---- stage 1: per-lamp hits and colours ----
  logic               vld_p1;
  logic [NUM_DIR-1:0] lamp_hit_p1;
  logic [NUM_DIR-1:0] ring_hit_p1;
  logic [11:0]        lamp_rgb_p1 [NUM_DIR];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_p1 <= 1'b0;
    else        vld_p1 <= pixel_valid;
  end

  always_ff @(posedge clk) begin
    lamp_hit_p1 <= lamp_hit;
    ring_hit_p1 <= ring_hit;
    lamp_rgb_p1 <= lamp_rgb_c;
  end

  // ---- stage 2: priority resolve and output register ----
  logic [11:0] sel_rgb;
  logic        sel_act;

  always_comb begin
    sel_rgb = 12'h000;
    sel_act = 1'b0;
    if (vld_p1) begin
      if (|ring_hit_p1) begin
        sel_rgb = 12'hFFF;
        sel_act = 1'b1;
      end
      // Descending scan: the lowest-index lamp hit is applied last and wins
      for (int i = NUM_DIR - 1; i >= 0; i--) begin
        if (lamp_hit_p1[i]) begin
          sel_rgb = lamp_rgb_p1[i];
          sel_act = 1'b1;
        end
      end
    end
  end

  logic        vld_p2;
  logic        act_p2;
  logic [11:0] rgb_p2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2 <= 1'b0;
      act_p2 <= 1'b0;
      rgb_p2 <= 12'h000;
    end else begin
      vld_p2 <= vld_p1;
      act_p2 <= sel_act;
      rgb_p2 <= sel_rgb;
    end
  end

  assign out_valid    = vld_p2;
  assign shape_active = act_p2;
  assign shape_r      = rgb_p2[11:8];
  assign shape_g      = rgb_p2[7:4];
  assign shape_b      = rgb_p2[3:0];

`ifdef TL_STATE_CHECK_EN
  logic fault_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           fault_q <= 1'b0;
    else if (frame_start && |bad_state)   fault_q <= 1'b1;
  end

  assign state_fault = fault_q;
`else
  assign state_fault = 1'b0;
`endif

endmodule

// File: tb/tb_traffic_light_pixel_renderer.sv
// Bench for traffic_light_pixel_renderer: directed steps plus random pixels against a rectangle-level model.
module tb_traffic_light_pixel_renderer;

  localparam int NUM_DIR      = 4;
  localparam int LAMP_SIZE    = 10;
  localparam int RING_W       = 2;
  localparam int BLINK_FRAMES = 2;
  localparam int LX [NUM_DIR] = '{130, 190, 110, 170};
  localparam int LY [NUM_DIR] = '{190, 170, 130, 110};

  logic                 clk;
  logic                 rst_n;
  logic                 pixel_valid;
  logic [9:0]           x;
  logic [9:0]           y;
  logic                 frame_start;
  logic [3*NUM_DIR-1:0] light_state;
  logic                 flash_mode;
  logic                 out_valid;
  logic                 shape_active;
  logic [3:0]           shape_r;
  logic [3:0]           shape_g;
  logic [3:0]           shape_b;
  logic                 state_fault;

  traffic_light_pixel_renderer #(.BLINK_FRAMES(BLINK_FRAMES)) dut (
    .clk(clk), .rst_n(rst_n), .pixel_valid(pixel_valid), .x(x), .y(y),
    .frame_start(frame_start), .light_state(light_state), .flash_mode(flash_mode),
    .out_valid(out_valid), .shape_active(shape_active), .shape_r(shape_r),
    .shape_g(shape_g), .shape_b(shape_b), .state_fault(state_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [2:0]  st_m [NUM_DIR];
  bit          flash_m;
  bit          blink_m;
  int          frames_m;
  bit          fault_m;
  logic [13:0] e_prev;

  function automatic logic [11:0] model_colour(logic [2:0] st);
    if (flash_m) return blink_m ? 12'hFF0 : 12'h000;
`ifdef TL_STATE_CHECK_EN
    if ($countones(st) != 1) return 12'hF0F;
`endif
    if (st[2]) return 12'hF00;
    if (st[1]) return 12'hFF0;
    if (st[0]) return 12'h0F0;
    return 12'h000;
  endfunction

  // {valid, active, rgb}
  function automatic logic [13:0] model_pixel(bit pv, int px, int py);
    int lo_x, lo_y;
    if (!pv) return 14'h0;
    for (int i = 0; i < NUM_DIR; i++)
      if (px >= LX[i] && px < LX[i] + LAMP_SIZE && py >= LY[i] && py < LY[i] + LAMP_SIZE)
        return {2'b11, model_colour(st_m[i])};
    for (int i = 0; i < NUM_DIR; i++) begin
      lo_x = (LX[i] - RING_W < 0) ? 0 : LX[i] - RING_W;
      lo_y = (LY[i] - RING_W < 0) ? 0 : LY[i] - RING_W;
      if (px >= lo_x && px < LX[i] + LAMP_SIZE + RING_W &&
          py >= lo_y && py < LY[i] + LAMP_SIZE + RING_W)
        return {2'b11, 12'hFFF};
    end
    return {2'b10, 12'h000};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_DIR; i++) st_m[i] = 3'b100;
    flash_m  = 1'b0;
    blink_m  = 1'b1;
    frames_m = 0;
    fault_m  = 1'b0;
    e_prev   = 14'h0;
  endtask

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] dut_rgb();
    return {shape_r, shape_g, shape_b};
  endfunction

  // One pixel clock: drive inputs, advance the model, then check the output for last cycle's pixel.
  task automatic cyc(input bit pv, input int px, input int py, input bit fs);
    logic [13:0] e_now;
    pixel_valid = pv;
    x           = px[9:0];
    y           = py[9:0];
    frame_start = fs;
    e_now = model_pixel(pv, px, py);
    if (fs) begin
      for (int i = 0; i < NUM_DIR; i++) begin
        st_m[i] = light_state[3*i +: 3];
`ifdef TL_STATE_CHECK_EN
        if ($countones(light_state[3*i +: 3]) != 1) fault_m = 1'b1;
`endif
      end
      flash_m = flash_mode;
      if (frames_m == BLINK_FRAMES - 1) begin
        frames_m = 0;
        blink_m  = !blink_m;
      end else begin
        frames_m++;
      end
    end
    @(posedge clk);
    #1;
    chk("out_valid", {11'h0, out_valid}, {11'h0, e_prev[13]});
    chk("shape_active", {11'h0, shape_active}, {11'h0, e_prev[12]});
    chk("rgb", dut_rgb(), e_prev[11:0]);
    chk("state_fault", {11'h0, state_fault}, {11'h0, fault_m});
    e_prev = e_now;
  endtask

  initial begin
    logic [3*NUM_DIR-1:0] ls;
    int                   li;
    int                   r;
    rst_n       = 1'b0;
    pixel_valid = 1'b0;
    x           = '0;
    y           = '0;
    frame_start = 1'b0;
    light_state = '0;
    flash_mode  = 1'b0;
    model_reset();

    #2;
    chk("reset_valid", {11'h0, out_valid}, 12'h0);
    chk("reset_active", {11'h0, shape_active}, 12'h0);
    chk("reset_rgb", dut_rgb(), 12'h000);
    chk("reset_fault", {11'h0, state_fault}, 12'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // all lamps green, lamp interior then ring then outside
    light_state = {NUM_DIR{3'b001}};
    cyc(1, 0, 0, 1);
    cyc(1, 170, 110, 0);
    cyc(1, 168, 110, 0);
    chk("tp_green", dut_rgb(), 12'h0F0);
    chk("tp_green_valid", {11'h0, out_valid}, 12'h1);
    cyc(1, 167, 110, 0);
    chk("tp_ring", dut_rgb(), 12'hFFF);
    cyc(1, 170, 110, 0);
    chk("tp_outside_act", {11'h0, shape_active}, 12'h0);
    chk("tp_outside_rgb", dut_rgb(), 12'h000);

    // mid-frame state change has no effect until frame_start
    light_state = {NUM_DIR{3'b010}};
    cyc(1, 170, 110, 0);
    cyc(1, 170, 110, 1);
    chk("tp_hold_green", dut_rgb(), 12'h0F0);
    cyc(1, 170, 110, 0);
    chk("tp_fs_pixel_old", dut_rgb(), 12'h0F0);
    cyc(1, 0, 0, 0);
    chk("tp_yellow", dut_rgb(), 12'hFF0);

    // flash mode across several blink half-periods; rings stay white
    flash_mode = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cyc(1, 170, 110, 1);
      cyc(1, 168, 110, 0);
      cyc(1, 131, 191, 0);
      chk("tp_flash_ring", dut_rgb(), 12'hFFF);
    end
    flash_mode = 1'b0;

    // non-one-hot lamp 0
    light_state = {3'b100, 3'b100, 3'b100, 3'b110};
    cyc(1, 0, 0, 1);
    cyc(1, 130, 190, 0);
    cyc(1, 0, 0, 0);
`ifdef TL_STATE_CHECK_EN
    chk("tp_bad_rgb", dut_rgb(), 12'hF0F);
    chk("tp_bad_fault", {11'h0, state_fault}, 12'h1);
`else
    chk("tp_bad_rgb", dut_rgb(), 12'hF00);
    chk("tp_bad_fault", {11'h0, state_fault}, 12'h0);
`endif

    // random pixels around lamps with random frame updates
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        for (int i = 0; i < NUM_DIR; i++) begin
          r = $urandom_range(0, 7);
          ls[3*i +: 3] = (r < 6) ? (3'b001 << (r % 3)) : 3'($urandom_range(0, 7));
        end
        light_state = ls;
        flash_mode  = ($urandom_range(0, 3) == 0);
        li = $urandom_range(0, NUM_DIR - 1);
        cyc($urandom_range(0, 7) != 0, LX[li] - 4 + $urandom_range(0, LAMP_SIZE + 7),
            LY[li] - 4 + $urandom_range(0, LAMP_SIZE + 7), 1);
      end else begin
        li = $urandom_range(0, NUM_DIR - 1);
        cyc($urandom_range(0, 7) != 0, LX[li] - 4 + $urandom_range(0, LAMP_SIZE + 7),
            LY[li] - 4 + $urandom_range(0, LAMP_SIZE + 7), 0);
      end
    end

    // asynchronous reset during a scan
    flash_mode  = 1'b0;
    light_state = {NUM_DIR{3'b001}};
    cyc(1, 170, 110, 1);
    cyc(1, 170, 110, 0);
    cyc(1, 170, 110, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", {11'h0, out_valid}, 12'h0);
    chk("rst_mid_active", {11'h0, shape_active}, 12'h0);
    chk("rst_mid_rgb", dut_rgb(), 12'h000);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1, 170, 110, 0);
    cyc(1, 0, 0, 0);
    chk("rst_red", dut_rgb(), 12'hF00);
    cyc(1, 130, 190, 1);
    cyc(1, 170, 110, 0);
    chk("rst_fs_old_red", dut_rgb(), 12'hF00);
    cyc(0, 0, 0, 0);
    chk("rst_after_fs_green", dut_rgb(), 12'h0F0);
    cyc(0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
